// File: rtl/out_shifter.sv
// Serial driver for a 74HC595-style expander: ships a coherent snapshot of the
// output latch whenever it differs from the last byte sent or a resend is forced.
module out_shifter #(
    parameter int unsigned DIV       = 4,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] outLatch,
    input  logic       enable,
    input  logic       force_req,
    output logic       sdata,
    output logic       sclk,
    output logic       rclk,
    output logic       busy,
    output logic       sent
);

    localparam int unsigned CW = 8;
    localparam int unsigned BW = 3;

    typedef enum logic [1:0] {IDLE, SHIFT_LO, SHIFT_HI, LATCH} state_t;

    state_t          state, state_n;
    logic [CW-1:0]   div_cnt, div_n;
    logic [BW-1:0]   bit_cnt, bit_n;
    logic [7:0]      snap, snap_n;
    logic [7:0]      last_sent, last_n;
    logic            pend_init, pinit_n;
    logic            pend_force, pforce_n;
    logic            sdata_n, sclk_n, rclk_n, busy_n, sent_n;
    logic            div_done;
    logic            req;

    // Bit of a byte that goes out in serial slot b
    function automatic logic pick(input logic [7:0] v, input logic [BW-1:0] b);
        return MSB_FIRST ? v[~b] : v[b];
    endfunction

    assign div_done = (div_cnt == CW'(DIV - 1));
    assign req      = enable & (pend_init | pend_force | force_req | (outLatch != last_sent));

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            snap       <= 8'h00;
            last_sent  <= 8'h00;
            pend_init  <= 1'b1;
            pend_force <= 1'b0;
            sdata      <= 1'b0;
            sclk       <= 1'b0;
            rclk       <= 1'b0;
            busy       <= 1'b0;
            sent       <= 1'b0;
        end else begin
            state      <= state_n;
            div_cnt    <= div_n;
            bit_cnt    <= bit_n;
            snap       <= snap_n;
            last_sent  <= last_n;
            pend_init  <= pinit_n;
            pend_force <= pforce_n;
            sdata      <= sdata_n;
            sclk       <= sclk_n;
            rclk       <= rclk_n;
            busy       <= busy_n;
            sent       <= sent_n;
        end
    end

    // Next state; outputs are computed for the state being entered
    always_comb begin
        state_n  = state;
        div_n    = div_cnt;
        bit_n    = bit_cnt;
        snap_n   = snap;
        last_n   = last_sent;
        pinit_n  = pend_init;
        pforce_n = pend_force;
        sdata_n  = sdata;
        sclk_n   = 1'b0;
        rclk_n   = 1'b0;
        busy_n   = 1'b1;
        sent_n   = 1'b0;

        if (state != IDLE && force_req) begin
            pforce_n = 1'b1;
        end

        case (state)
            IDLE: begin
                busy_n = 1'b0;
                if (req) begin
                    snap_n   = outLatch;
                    last_n   = outLatch;
                    pinit_n  = 1'b0;
                    pforce_n = 1'b0;
                    bit_n    = '0;
                    div_n    = '0;
                    state_n  = SHIFT_LO;
                    busy_n   = 1'b1;
                    sdata_n  = pick(outLatch, '0);
                end
            end
            SHIFT_LO: begin
                if (div_done) begin
                    div_n   = '0;
                    state_n = SHIFT_HI;
                    sclk_n  = 1'b1;
                end else begin
                    div_n = CW'(div_cnt + 1'b1);
                end
            end
            SHIFT_HI: begin
                sclk_n = 1'b1;
                if (div_done) begin
                    div_n  = '0;
                    sclk_n = 1'b0;
                    if (bit_cnt == BW'(7)) begin
                        state_n = LATCH;
                        rclk_n  = 1'b1;
                    end else begin
                        bit_n   = BW'(bit_cnt + 1'b1);
                        state_n = SHIFT_LO;
                        sdata_n = pick(snap, BW'(bit_cnt + 1'b1));
                    end
                end else begin
                    div_n = CW'(div_cnt + 1'b1);
                end
            end
            LATCH: begin
                rclk_n = 1'b1;
                if (div_done) begin
                    div_n   = '0;
                    rclk_n  = 1'b0;
                    busy_n  = 1'b0;
                    sent_n  = 1'b1;
                    state_n = IDLE;
                end else begin
                    div_n = CW'(div_cnt + 1'b1);
                end
            end
            default: begin
                state_n = IDLE;
                busy_n  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_out_shifter.sv
// Bench for out_shifter: two instances (DIV=2 MSB-first, DIV=1 LSB-first) checked
// cycle by cycle against a frame-timing model, plus hand-computed frame checks.
module tb_out_shifter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] ol [2];
    logic [1:0] en  = 2'b00;
    logic [1:0] frc = 2'b00;
    logic [1:0] sdata, sclk, rclk, busy, sent;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    out_shifter #(.DIV(2), .MSB_FIRST(1'b1)) u0 (
        .clk(clk), .rst(rst), .outLatch(ol[0]), .enable(en[0]), .force_req(frc[0]),
        .sdata(sdata[0]), .sclk(sclk[0]), .rclk(rclk[0]), .busy(busy[0]), .sent(sent[0]));

    out_shifter #(.DIV(1), .MSB_FIRST(1'b0)) u1 (
        .clk(clk), .rst(rst), .outLatch(ol[1]), .enable(en[1]), .force_req(frc[1]),
        .sdata(sdata[1]), .sclk(sclk[1]), .rclk(rclk[1]), .busy(busy[1]), .sent(sent[1]));

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got 0x%0h want 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Frame model: t = offset of the current cycle inside a frame, 0 when idle
    int         m_t     [2];
    logic [7:0] m_snap  [2];
    logic [7:0] m_last  [2];
    bit         m_pi    [2];
    bit         m_pf    [2];
    bit         m_sent  [2];

    function automatic int dv(input int i);
        return (i == 0) ? 2 : 1;
    endfunction

    function automatic logic slot_bit(input int i, input logic [7:0] v, input int k);
        int sh;
        sh = (i == 0) ? 7 - k : k;
        return v[sh[2:0]];
    endfunction

    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_t[i] = 0; m_snap[i] = 8'h00; m_last[i] = 8'h00;
                m_pi[i] = 1'b1; m_pf[i] = 1'b0; m_sent[i] = 1'b0;
            end else if (m_t[i] > 0) begin
                m_sent[i] = 1'b0;
                if (frc[i]) m_pf[i] = 1'b1;
                if (m_t[i] == 17 * dv(i)) begin
                    m_t[i] = 0;
                    m_sent[i] = 1'b1;
                end else begin
                    m_t[i] = m_t[i] + 1;
                end
            end else begin
                m_sent[i] = 1'b0;
                if (en[i] && (m_pi[i] || m_pf[i] || frc[i] || ol[i] != m_last[i])) begin
                    m_snap[i] = ol[i]; m_last[i] = ol[i];
                    m_pi[i] = 1'b0; m_pf[i] = 1'b0;
                    m_t[i] = 1;
                end
            end
        end
    end

    // Expected {busy, sclk, rclk, sdata, sent}
    function automatic logic [4:0] expv(input int i);
        int t, d;
        t = m_t[i];
        d = dv(i);
        if (t == 0)
            return {1'b0, 1'b0, 1'b0, slot_bit(i, m_snap[i], 7), m_sent[i]};
        else if (t <= 16 * d)
            return {1'b1, (((t - 1) / d) % 2) == 1, 1'b0, slot_bit(i, m_snap[i], (t - 1) / (2 * d)), 1'b0};
        else
            return {1'b1, 1'b0, 1'b1, slot_bit(i, m_snap[i], 7), 1'b0};
    endfunction

    always @(negedge clk) begin
        if (chk_on) begin
            for (int i = 0; i < 2; i++)
                chk($sformatf("outs%0d", i),
                    int'({busy[i], sclk[i], rclk[i], sdata[i], sent[i]}), int'(expv(i)));
        end
    end

    // Frame capture as the expander would see it
    int         frames   [2] = '{0, 0};
    logic [7:0] acc      [2];
    logic [7:0] lastbyte [2];
    int         busy_cnt [2] = '{0, 0};
    int         rclk_cnt [2] = '{0, 0};
    int         sent_cnt [2] = '{0, 0};
    int         rise_cyc [2] = '{0, 0};
    int         sent_cyc [2] = '{0, 0};
    int         gap      [2] = '{0, 0};
    logic [1:0] psclk = 2'b00, prclk = 2'b00, pbusy = 2'b00;

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (sclk[i] && !psclk[i])
                acc[i] = (i == 0) ? {acc[i][6:0], sdata[i]} : {sdata[i], acc[i][7:1]};
            if (rclk[i] && !prclk[i]) begin
                frames[i]++;
                lastbyte[i] = acc[i];
                rise_cyc[i] = cyc;
            end
            if (rclk[i]) rclk_cnt[i]++;
            if (busy[i]) busy_cnt[i]++;
            if (busy[i] && !pbusy[i]) gap[i] = cyc - sent_cyc[i];
            if (sent[i]) begin
                sent_cnt[i]++;
                sent_cyc[i] = cyc;
            end
        end
        psclk = sclk;
        prclk = rclk;
        pbusy = busy;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    int f0, f1, chg;

    initial begin
        ol[0] = 8'h00;
        ol[1] = 8'h00;
        step(2);
        chk_on = 1'b1;
        chk("reset_busy", int'(busy[0]), 0);

        // Power-up frame of 0x00
        en[0] = 1'b1;
        rst = 1'b0;
        step(50);
        chk("init_frames", frames[0], 1);
        chk("init_byte", int'(lastbyte[0]), 8'h00);
        chk("init_busy_len", busy_cnt[0], 34);
        chk("init_rclk_len", rclk_cnt[0], 2);
        chk("init_sent", sent_cnt[0], 1);
        step(30);
        chk("quiet_frames", frames[0], 1);

        // Change to 0xA5, then two mid-frame changes collapse to one follow-up
        f0 = frames[0];
        chg = cyc;
        ol[0] = 8'hA5;
        step(10);
        ol[0] = 8'h3C;
        step(10);
        ol[0] = 8'h81;
        step(20);
        chk("a5_byte", int'(lastbyte[0]), 8'hA5);
        chk("a5_latency", rise_cyc[0] - chg, 33);
        step(60);
        chk("follow_frames", frames[0] - f0, 2);
        chk("follow_byte", int'(lastbyte[0]), 8'h81);
        chk("follow_gap", gap[0], 1);

        // Idle force, then a mid-frame force: two resends
        f0 = frames[0];
        frc[0] = 1'b1;
        step(1);
        frc[0] = 1'b0;
        step(10);
        frc[0] = 1'b1;
        step(1);
        frc[0] = 1'b0;
        step(100);
        chk("force_frames", frames[0] - f0, 2);
        chk("force_byte", int'(lastbyte[0]), 8'h81);

        // Reset during bit 4 of a 0x0F frame
        f0 = frames[0];
        f1 = frames[1];
        ol[0] = 8'h0F;
        step(17);
        chk("pre_rst_busy", int'(busy[0]), 1);
        chk("pre_rst_sdata", int'(sdata[0]), 1);
        rst = 1'b1;
        #1;
        chk("rst_outs", int'({busy[0], sclk[0], rclk[0], sdata[0]}), 0);
        step(1);
        rst = 1'b0;
        step(50);
        chk("rst_frames", frames[0] - f0, 1);
        chk("rst_byte", int'(lastbyte[0]), 8'h0F);
        chk("u1_disabled", frames[1] - f1, 0);

        // LSB-first, DIV=1 instance
        f1 = busy_cnt[1];
        ol[1] = 8'h01;
        en[1] = 1'b1;
        step(30);
        chk("lsb_frames", frames[1], 1);
        chk("lsb_byte", int'(lastbyte[1]), 8'h01);
        chk("lsb_busy_len", busy_cnt[1] - f1, 17);
        en[1] = 1'b0;
        step(1);
        ol[1] = 8'h02;
        step(30);
        chk("lsb_blocked", frames[1], 1);
        en[1] = 1'b1;
        step(30);
        chk("lsb_resume", frames[1], 2);
        chk("lsb_byte2", int'(lastbyte[1]), 8'h02);

        step(2);
        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/out_shifter.md
# out_shifter

Serial output driver downstream of the output selector latch. Watches the 8-bit output latch value and, whenever it differs from the last value transmitted (or a resend is forced), shifts a snapshot out on a 3-wire serial bus (data, shift clock, latch strobe) to an external 74HC595-style expander. Snapshots are taken only between frames, so every transmitted byte is a coherent latch value.

## Interface
- DIV, 4: clk cycles per serial-clock half-period; legal range 1..255
- MSB_FIRST, 1: 1 = bit 7 shifted first, 0 = bit 0 shifted first
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  reset, asynchronous, active-high
- outLatch  input  8  current output latch value from the output selector
- enable  input  1  permits new frames to start; an in-flight frame always completes
- force  input  1  request a resend of the current outLatch even if unchanged
- sdata  output  1  serial data to expander
- sclk  output  1  serial shift clock; expander samples sdata on its rising edge
- rclk  output  1  latch strobe; expander transfers shift register to pins on its rising edge
- busy  output  1  high while a frame is in progress
- sent  output  1  one-cycle pulse after each completed frame

## Operation
- Internal state: lastSent[7:0], snap[7:0], pendInit, pendForce, bit counter 0..7, divider counter 0..DIV-1.
- States: IDLE, SHIFT_LO, SHIFT_HI, LATCH.
- IDLE: request = enable & (pendInit | pendForce | force | outLatch != lastSent). On a request: snap <= outLatch, lastSent <= outLatch, clear pendInit and pendForce, bit counter <= 0, go to SHIFT_LO.
- SHIFT_LO (DIV cycles): sclk low, sdata = snap[7-bit] (MSB_FIRST=1) or snap[bit] (MSB_FIRST=0), stable for the whole state. Then SHIFT_HI.
- SHIFT_HI (DIV cycles): sclk high, sdata unchanged. Then bit==7 -> LATCH, else bit+1 and SHIFT_LO.
- LATCH (DIV cycles): sclk low, rclk high, sdata held at the last bit. Then IDLE with sent pulsed.
- force seen while not in IDLE sets pendForce; it is served by the next frame.
- outLatch changes mid-frame do not affect snap; the mismatch with lastSent triggers the next frame.
- enable deasserted mid-frame: frame completes normally; no new frame starts until enable returns. Pending flags are kept.
- Reset: sdata=0, sclk=0, rclk=0, busy=0, sent=0, lastSent=0x00, snap=0x00, pendForce=0, pendInit=1 (the first enabled frame after reset always transmits, so the expander is synchronised even when outLatch is 0x00). State goes to IDLE and counters to 0. Reset mid-frame aborts immediately; rclk is not pulsed.

## Timing
- Request evaluated in IDLE cycle N. The frame occupies cycles N+1 .. N+17*DIV. busy is registered high over exactly those cycles.
- Bit k (k=0..7): sclk low for cycles N+1+2k*DIV .. N+(2k+1)*DIV, high for N+1+(2k+1)*DIV .. N+(2k+2)*DIV.
- rclk high over cycles N+16*DIV+1 .. N+17*DIV.
- Cycle N+17*DIV+1: back in IDLE, busy=0, sent=1. A request in this cycle starts the next frame, giving back-to-back frames separated by exactly one IDLE cycle.
- All outputs are registered with no combinational path from inputs. sdata changes only on entry to SHIFT_LO.
- Minimum update latency: outLatch change at cycle N gives rclk rising at N+16*DIV+1.

## Test plan
- DIV=2, reset, enable=1, outLatch=0x00: exactly one frame of eight 0 bits; busy high for 34 cycles; one rclk pulse of 2 cycles; sent pulses once; then idle with no further frames.
- outLatch 0x00->0xA5 in IDLE (MSB_FIRST=1): bits sampled at sclk rises are 1,0,1,0,0,1,0,1; rclk rises 33 cycles after the change cycle.
- During the 0xA5 frame, set outLatch 0x3C then 0x81: the first frame still sends 0xA5; exactly one follow-up frame sends 0x81, starting on the sent cycle.
- force pulse with outLatch unchanged in IDLE, then another force pulse mid-frame: each force produces one resend of the same byte, giving 2 frames total.
- Assert rst at bit 4 of a frame: sclk, rclk, sdata and busy are 0 in the same cycle. After release with enable=1, a full frame sends the current outLatch.
- MSB_FIRST=0, DIV=1, outLatch=0x01: first sampled bit is 1 and the rest are 0; busy lasts 17 cycles; enable=0 before a change blocks any new frame.
